// File: rtl/serializador_pixel.sv
// Pixel FIFO: small synchronous FIFO holding {last, pixel} words between the pixel source and the serializer.
// Latency: a word written at edge N is visible at dout after edge N (no bypass; level updates the same edge).
// Backpressure: writes are dropped when full and reads are ignored when empty; callers gate on level.
module fifo_pixel #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (level != LW'(DEPTH));
    assign pop_ok  = pop && (level != '0);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because level gates every read.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy 0..DEPTH.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// Pixel serializer: buffers 16-bit pixels and emits each as two bytes, order set by MSB_FIRST.
// Latency: pixel pushed at edge N into an idle, empty block shows its first byte after edge N+1.
// Backpressure: byte outputs hold while byte_ready=0; pixel_ready drops when the FIFO is full.
module serializador_pixel #(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic [15:0]            pixel_in,
    input  logic                   pixel_last,
    input  logic                   pixel_valid,
    output logic                   pixel_ready,
    output logic [7:0]             byte_out,
    output logic                   byte_last,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic [15:0]            pixel_count,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int LW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        PRIMEIRO = 2'd1,
        SEGUNDO  = 2'd2
    } estado_t;

    estado_t     state;
    logic [16:0] head;
    logic [7:0]  head_first;
    logic [7:0]  head_second;
    logic [7:0]  second_byte;
    logic        last_flag;
    logic        fifo_empty;
    logic        pop;

    fifo_pixel #(
        .W     (17),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .clear (clear),
        .push  (pixel_valid && pixel_ready),
        .pop   (pop),
        .din   ({pixel_last, pixel_in}),
        .dout  (head),
        .level (fifo_level)
    );

    // Ready depends only on registered occupancy, so a same-edge pop never frees a full FIFO.
    assign pixel_ready = (fifo_level != LW'(DEPTH));
    assign fifo_empty  = (fifo_level == '0);
    assign head_first  = MSB_FIRST ? head[15:8] : head[7:0];
    assign head_second = MSB_FIRST ? head[7:0]  : head[15:8];

    // Pop when idle, or when the second byte leaves so the next pixel follows without a bubble.
    assign pop = !fifo_empty &&
                 ((state == OCIOSO) || ((state == SEGUNDO) && byte_ready));

    // Byte FSM with registered outputs; nothing changes while a byte waits for byte_ready.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state       <= OCIOSO;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            byte_last   <= 1'b0;
            pixel_count <= '0;
            second_byte <= '0;
            last_flag   <= 1'b0;
        end else begin
            case (state)
                OCIOSO: begin
                    if (!fifo_empty) begin
                        byte_out    <= head_first;
                        second_byte <= head_second;
                        last_flag   <= head[16];
                        byte_valid  <= 1'b1;
                        byte_last   <= 1'b0;
                        state       <= PRIMEIRO;
                    end
                end
                PRIMEIRO: begin
                    if (byte_ready) begin
                        byte_out  <= second_byte;
                        byte_last <= last_flag;
                        state     <= SEGUNDO;
                    end
                end
                SEGUNDO: begin
                    if (byte_ready) begin
                        pixel_count <= pixel_count + 16'd1;
                        if (!fifo_empty) begin
                            byte_out    <= head_first;
                            second_byte <= head_second;
                            last_flag   <= head[16];
                            byte_valid  <= 1'b1;
                            byte_last   <= 1'b0;
                            state       <= PRIMEIRO;
                        end else begin
                            byte_valid <= 1'b0;
                            byte_last  <= 1'b0;
                            state      <= OCIOSO;
                        end
                    end
                end
                default: begin
                    byte_valid <= 1'b0;
                    byte_last  <= 1'b0;
                    state      <= OCIOSO;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serializador_pixel.sv
module tb_serializador_pixel;
    logic        clock;
    logic        clear;

    // Instance A: MSB first, depth 4
    logic [15:0] pixel_in;
    logic        pixel_last;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [7:0]  byte_out;
    logic        byte_last;
    logic        byte_valid;
    logic        byte_ready;
    logic [15:0] pixel_count;
    logic [2:0]  fifo_level;

    // Instance B: LSB first, depth 4
    logic [15:0] pixel_in_b;
    logic        pixel_last_b;
    logic        pixel_valid_b;
    logic        pixel_ready_b;
    logic [7:0]  byte_out_b;
    logic        byte_last_b;
    logic        byte_valid_b;
    logic        byte_ready_b;
    logic [15:0] pixel_count_b;
    logic [2:0]  fifo_level_b;

    int tests;
    int fails;

    serializador_pixel #(.DEPTH(4), .MSB_FIRST(1'b1)) dut (
        .clock       (clock),
        .clear       (clear),
        .pixel_in    (pixel_in),
        .pixel_last  (pixel_last),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .byte_out    (byte_out),
        .byte_last   (byte_last),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .pixel_count (pixel_count),
        .fifo_level  (fifo_level)
    );

    serializador_pixel #(.DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clock       (clock),
        .clear       (clear),
        .pixel_in    (pixel_in_b),
        .pixel_last  (pixel_last_b),
        .pixel_valid (pixel_valid_b),
        .pixel_ready (pixel_ready_b),
        .byte_out    (byte_out_b),
        .byte_last   (byte_last_b),
        .byte_valid  (byte_valid_b),
        .byte_ready  (byte_ready_b),
        .pixel_count (pixel_count_b),
        .fifo_level  (fifo_level_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        pv;
        logic [15:0] px;
        logic        pl;
        logic        br;
        logic        ev;
        logic [7:0]  eb;
        logic        el;
        logic        er;
        logic [2:0]  elev;
        logic [15:0] ecnt;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Advance one rising edge and settle away from it
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [29:0] pack_a();
        return {byte_valid, (byte_valid ? byte_out : 8'h00), byte_last, pixel_ready,
                fifo_level, pixel_count};
    endfunction

    initial begin
        logic [15:0] bp_px [4];
        logic [7:0]  drain [7];
        logic [2:0]  bp_lev [5];
        logic [29:0] exp_row;

        tests = 0;
        fails = 0;

        // Single pixel, then back-to-back stream of three
        tbl[0]  = '{1'b1, 16'hF81F, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 16'd0};
        tbl[1]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hF8, 1'b0, 1'b1, 3'd0, 16'd0};
        tbl[2]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h1F, 1'b1, 1'b1, 3'd0, 16'd0};
        tbl[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 16'd1};
        tbl[4]  = '{1'b1, 16'h1234, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd1, 16'd1};
        tbl[5]  = '{1'b1, 16'hABCD, 1'b0, 1'b1, 1'b1, 8'h12, 1'b0, 1'b1, 3'd1, 16'd1};
        tbl[6]  = '{1'b1, 16'h0F0F, 1'b0, 1'b1, 1'b1, 8'h34, 1'b0, 1'b1, 3'd2, 16'd1};
        tbl[7]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hAB, 1'b0, 1'b1, 3'd1, 16'd2};
        tbl[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'hCD, 1'b0, 1'b1, 3'd1, 16'd2};
        tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1, 3'd0, 16'd3};
        tbl[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b1, 3'd0, 16'd3};
        tbl[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 3'd0, 16'd4};

        bp_px[0] = 16'h2222; bp_px[1] = 16'h3333; bp_px[2] = 16'h4444; bp_px[3] = 16'h5555;
        bp_lev[0] = 3'd2; bp_lev[1] = 3'd3; bp_lev[2] = 3'd4; bp_lev[3] = 3'd4; bp_lev[4] = 3'd4;
        drain[0] = 8'h11; drain[1] = 8'h22; drain[2] = 8'h22; drain[3] = 8'h33;
        drain[4] = 8'h33; drain[5] = 8'h44; drain[6] = 8'h44;

        clear = 1'b0;
        pixel_in = '0; pixel_last = 1'b0; pixel_valid = 1'b0; byte_ready = 1'b0;
        pixel_in_b = '0; pixel_last_b = 1'b0; pixel_valid_b = 1'b0; byte_ready_b = 1'b1;

        // Reset state
        #1;
        chk("reset_byte_valid", 64'(byte_valid), 64'd0);
        chk("reset_byte_out", 64'(byte_out), 64'd0);
        chk("reset_byte_last", 64'(byte_last), 64'd0);
        chk("reset_fifo_level", 64'(fifo_level), 64'd0);
        chk("reset_pixel_count", 64'(pixel_count), 64'd0);
        chk("reset_pixel_ready", 64'(pixel_ready), 64'd1);
        step();
        step();
        clear = 1'b1;

        // Table-driven single pixel and stream
        for (int i = 0; i < 12; i++) begin
            pixel_valid = tbl[i].pv;
            pixel_in    = tbl[i].px;
            pixel_last  = tbl[i].pl;
            byte_ready  = tbl[i].br;
            step();
            exp_row = {tbl[i].ev, tbl[i].eb, tbl[i].el, tbl[i].er, tbl[i].elev, tbl[i].ecnt};
            chk($sformatf("vec%0d", i), 64'(pack_a()), 64'(exp_row));
        end

        // Backpressure: hold 0x12 while the FIFO fills
        pixel_valid = 1'b1; pixel_in = 16'h1234; pixel_last = 1'b0; byte_ready = 1'b0;
        step();
        chk("bp_push_level", 64'(fifo_level), 64'd1);
        pixel_in = 16'h1111;
        step();
        chk("bp_first_byte", 64'({byte_valid, byte_out}), 64'({1'b1, 8'h12}));
        for (int k = 0; k < 5; k++) begin
            pixel_valid = (k < 4);
            pixel_in    = (k < 4) ? bp_px[k] : 16'h0000;
            step();
            chk($sformatf("bp_hold%0d", k), 64'({byte_valid, byte_out, fifo_level}),
                64'({1'b1, 8'h12, bp_lev[k]}));
            if (k >= 2) chk($sformatf("bp_ready%0d", k), 64'(pixel_ready), 64'd0);
        end

        // Release; then full FIFO with simultaneous pop and push attempt
        pixel_valid = 1'b0; byte_ready = 1'b1;
        step();
        chk("bp_second_byte", 64'({byte_out, fifo_level, pixel_ready}), 64'({8'h34, 3'd4, 1'b0}));
        pixel_valid = 1'b1; pixel_in = 16'h5555;
        step();
        pixel_valid = 1'b0;
        chk("full_pop_level", 64'(fifo_level), 64'd3);
        chk("full_pop_ready", 64'(pixel_ready), 64'd1);
        chk("full_pop_byte", 64'({byte_valid, byte_out}), 64'({1'b1, 8'h11}));
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("drain%0d", k), 64'({byte_valid, byte_out}), 64'({1'b1, drain[k]}));
        end
        step();
        chk("drain_idle", 64'({byte_valid, fifo_level, pixel_count}), 64'({1'b0, 3'd0, 16'd9}));

        // LSB-first instance
        pixel_valid_b = 1'b1; pixel_in_b = 16'hBEEF; pixel_last_b = 1'b1;
        step();
        pixel_valid_b = 1'b0;
        chk("lsb_push", 64'({byte_valid_b, fifo_level_b}), 64'({1'b0, 3'd1}));
        step();
        chk("lsb_first", 64'({byte_valid_b, byte_out_b, byte_last_b}), 64'({1'b1, 8'hEF, 1'b0}));
        step();
        chk("lsb_second", 64'({byte_valid_b, byte_out_b, byte_last_b}), 64'({1'b1, 8'hBE, 1'b1}));
        step();
        chk("lsb_done", 64'({byte_valid_b, pixel_count_b}), 64'({1'b0, 16'd1}));

        // Asynchronous reset while in the second byte with two pixels queued
        pixel_valid = 1'b1; pixel_in = 16'hAAAA; byte_ready = 1'b0;
        step();
        pixel_in = 16'hBBBB;
        step();
        pixel_in = 16'hCCCC;
        step();
        pixel_valid = 1'b0; byte_ready = 1'b1;
        step();
        byte_ready = 1'b0;
        chk("rst_pre_state", 64'({byte_valid, byte_out, fifo_level}), 64'({1'b1, 8'hAA, 3'd2}));
        #2;
        clear = 1'b0;
        #1;
        chk("rst_async_valid", 64'(byte_valid), 64'd0);
        chk("rst_async_level", 64'(fifo_level), 64'd0);
        chk("rst_async_count", 64'(pixel_count), 64'd0);
        chk("rst_async_out", 64'({byte_out, byte_last, pixel_ready}), 64'({8'h00, 1'b0, 1'b1}));
        step();
        clear = 1'b1;
        byte_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rst_no_stale%0d", k), 64'({byte_valid, fifo_level, pixel_count}),
                64'({1'b0, 3'd0, 16'd0}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serializador_pixel.md
# serializador_pixel

Pixel-to-byte serializer for the camera/image datapath. It accepts 16-bit pixels (RGB565 words as assembled by the byte-pairing pixel register) over a valid/ready handshake and buffers them in a small FIFO. It emits each pixel as two 8-bit bytes over a second valid/ready handshake toward the byte-wide link (UART/transmit side). It is the transmit-direction counterpart of the 8-to-16 pixel assembler.

## Interface
- DEPTH, 4, pixel FIFO depth; power of two, at least 2
- MSB_FIRST, 1, 1 = high byte [15:8] sent first; 0 = low byte [7:0] sent first
- clock  input  1  system clock, rising edge
- clear  input  1  reset; asynchronous, active-low (0 = reset)
- pixel_in  input  16  pixel word
- pixel_last  input  1  marks the final pixel of a frame; travels with pixel_in
- pixel_valid  input  1  pixel_in/pixel_last valid
- pixel_ready  output  1  FIFO can accept a pixel
- byte_out  output  8  serialized byte
- byte_last  output  1  high on the second byte of a pixel tagged pixel_last
- byte_valid  output  1  byte_out valid
- byte_ready  input  1  downstream accepts byte_out
- pixel_count  output  16  number of pixels fully sent; wraps modulo 2^16
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Push: pixel_valid && pixel_ready at a rising edge stores {pixel_last, pixel_in} in the FIFO.
- pixel_ready = (fifo_level != DEPTH), computed from registered state only.
  - A pop in the same cycle does not make a full FIFO ready.
- Byte transfer occurs on byte_valid && byte_ready at a rising edge.
- byte_out, byte_valid and byte_last are registered outputs.
- FSM states:
  - OCIOSO: byte_valid=0.
    - FIFO non-empty: pop the head into the shift register, present the first byte, go to PRIMEIRO.
  - PRIMEIRO: byte_valid=1, first byte presented, byte_last=0.
    - On transfer: present the second byte, set byte_last = stored last flag, go to SEGUNDO.
  - SEGUNDO: byte_valid=1, second byte presented.
    - On transfer: pixel_count += 1.
    - If the FIFO is non-empty: pop in the same edge, present the next pixel's first byte, go to PRIMEIRO.
    - Otherwise: go to OCIOSO.
- No transfer in PRIMEIRO or SEGUNDO: byte_out, byte_last and state hold stable (no byte may change while byte_valid=1 and byte_ready=0).
- Push and pop in the same edge: both take effect; fifo_level is unchanged.
- Push into an empty FIFO while in OCIOSO: the pixel is not visible to the FSM until the next edge (no bypass path).
- Pointers wrap modulo DEPTH; fifo_level ranges 0..DEPTH.
- pixel_valid while pixel_ready=0: ignored. The source must hold the data.
- Reset (clear=0), asynchronous, at any time including mid-pixel:
  - State=OCIOSO, FIFO emptied (pointers 0, fifo_level=0).
  - byte_out=0, byte_valid=0, byte_last=0, pixel_count=0.
  - pixel_ready=1 once reset is released (it reads 1 during reset as well, since fifo_level=0).
  - A partially sent pixel is discarded.

## Timing
- Latency: pixel pushed at edge N into an empty, idle block → byte_valid=1 with the first byte after edge N+1.
- Second byte follows one edge after the first transfer.
- Throughput: with byte_ready held 1 and the FIFO non-empty, one byte per cycle with no bubble between pixels.
- Sustained input rate is therefore one pixel per two cycles.
- pixel_count updates on the edge that transfers the second byte; it is visible the following cycle.
- byte_last is high only while the second byte of a last-tagged pixel is presented.

## Test plan
- Single pixel:
  - Stimulus: reset, push 0xF81F with pixel_last=1, byte_ready=1.
  - Required: byte_valid rises 2 cycles after push; bytes 0xF8 then 0x1F on consecutive cycles; byte_last=1 only on 0x1F; pixel_count=1; then OCIOSO.
- Back-to-back stream:
  - Stimulus: push 0x1234, 0xABCD, 0x0F0F, byte_ready=1.
  - Required: 6 consecutive bytes 12,34,AB,CD,0F,0F with no idle cycle; pixel_count=3.
- Backpressure:
  - Stimulus: byte_ready=0 for 5 cycles while 0x1234's first byte is presented.
  - Required: byte_out holds 0x12 and byte_valid=1 throughout.
  - Stimulus, continued: pixels pushed meanwhile.
  - Required: FIFO fills to DEPTH=4; pixel_ready=0; an extra push is not accepted. After release, all 4 buffered pixels plus the held one emerge in order.
- Full with simultaneous pop:
  - Stimulus: FIFO full, pop occurs, pixel_valid=1 in the same cycle.
  - Required: push rejected; fifo_level=3 next cycle, then pixel_ready=1.
- MSB_FIRST=0:
  - Stimulus: push 0xBEEF.
  - Required: bytes 0xEF then 0xBE.
- Reset mid-operation:
  - Stimulus: clear=0 asynchronously while in SEGUNDO with 2 pixels queued.
  - Required: byte_valid=0, fifo_level=0, pixel_count=0 immediately, without waiting for a clock edge. After release, no stale bytes are emitted.
